// File: rtl/sa_fifo_ctrl_61x514.sv
// FIFO controller for a 61x514 two-stage-read RAM; in accept -> out_pvld in 3 cycles, 1 entry/cycle steady state.
// Backpressure: in_prdy drops when 61 entries wait in RAM; out_prdy=0 holds dout_r and s1. Optional SA_FIFO_CTRL_HWM_EN adds a used high-water mark.
module sa_fifo_ctrl_61x514 #(
  parameter int DEPTH = 61,
  parameter int WIDTH = 514,
  parameter int AW    = 6,
  parameter int CW    = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_pvld,
  output logic             in_prdy,
  input  logic [WIDTH-1:0] in_pd,
  output logic             out_pvld,
  input  logic             out_prdy,
  output logic [WIDTH-1:0] out_pd,
  output logic [AW-1:0]    ram_wa,
  output logic             ram_we,
  output logic [WIDTH-1:0] ram_di,
  output logic [AW-1:0]    ram_ra,
  output logic             ram_re,
  output logic             ram_ore,
  input  logic [WIDTH-1:0] ram_dout,
`ifdef SA_FIFO_CTRL_HWM_EN
  input  logic             hwm_clr,
  output logic [CW-1:0]    used_hwm,
`endif
  output logic [CW-1:0]    fifo_used
);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] used, avail;
  logic          s1_vld, s2_vld;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [CW-1:0] cnt_upd(input logic [CW-1:0] c, input logic inc, input logic dec);
    logic [CW-1:0] r;
    r = c;
    if (inc && !dec) r = c + 1'b1;
    else if (!inc && dec) r = c - 1'b1;
    return r;
  endfunction

  assign in_prdy   = !rst && (used < CW'(DEPTH));
  assign ram_we    = in_pvld && in_prdy;
  assign ram_wa    = wr_ptr;
  assign ram_di    = in_pd;

  // Entries are freed on ore only: the RAM reads mem[ra_d] combinationally, so a held s1 slot must stay intact.
  assign ram_ore   = s1_vld && (!s2_vld || out_prdy);
  assign ram_re    = (avail != '0) && (!s1_vld || ram_ore);
  assign ram_ra    = rd_ptr;

  assign out_pvld  = s2_vld;
  assign out_pd    = ram_dout;
  assign fifo_used = used;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
      avail  <= '0;
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      if (ram_we) wr_ptr <= ptr_inc(wr_ptr);
      if (ram_re) rd_ptr <= ptr_inc(rd_ptr);
      used  <= cnt_upd(used, ram_we, ram_ore);
      avail <= cnt_upd(avail, ram_we, ram_re);
      if (ram_re) s1_vld <= 1'b1;
      else if (ram_ore) s1_vld <= 1'b0;
      if (ram_ore) s2_vld <= 1'b1;
      else if (out_prdy) s2_vld <= 1'b0;
    end
  end

`ifdef SA_FIFO_CTRL_HWM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) used_hwm <= '0;
    else if (hwm_clr) used_hwm <= used;
    else if (used > used_hwm) used_hwm <= used;
  end
`endif

endmodule

// File: tb/tb_sa_fifo_ctrl_61x514.sv
// Bench for sa_fifo_ctrl_61x514 with a behavioural 61x514 two-stage-read RAM and a data scoreboard.
module tb_sa_fifo_ctrl_61x514;
  localparam int DEPTH = 61;
  localparam int WIDTH = 514;
  localparam int AW    = 6;
  localparam int CW    = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_pvld, in_prdy, out_pvld, out_prdy;
  logic [WIDTH-1:0] in_pd, out_pd, ram_di, ram_dout;
  logic [AW-1:0]    ram_wa, ram_ra;
  logic             ram_we, ram_re, ram_ore;
  logic [CW-1:0]    fifo_used;
`ifdef SA_FIFO_CTRL_HWM_EN
  logic             hwm_clr = 1'b0;
  logic [CW-1:0]    used_hwm;
`endif

  sa_fifo_ctrl_61x514 dut (
    .clk(clk), .rst(rst),
    .in_pvld(in_pvld), .in_prdy(in_prdy), .in_pd(in_pd),
    .out_pvld(out_pvld), .out_prdy(out_prdy), .out_pd(out_pd),
    .ram_wa(ram_wa), .ram_we(ram_we), .ram_di(ram_di),
    .ram_ra(ram_ra), .ram_re(ram_re), .ram_ore(ram_ore), .ram_dout(ram_dout),
`ifdef SA_FIFO_CTRL_HWM_EN
    .hwm_clr(hwm_clr), .used_hwm(used_hwm),
`endif
    .fifo_used(fifo_used)
  );

  always #5 clk = ~clk;

  // RAM model: re latches the address, ore registers mem[ra_d].
  logic [WIDTH-1:0] mem [0:DEPTH-1];
  logic [AW-1:0]    ra_d = '0;
  logic [WIDTH-1:0] dout_r = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ra_d <= ram_ra;
    if (ram_ore) dout_r <= mem[ra_d];
  end
  assign ram_dout = dout_r;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int pop_cnt = 0;
  int last_pop_cyc = 0;
  int max_used = 0;
  logic [WIDTH-1:0] sb [$];
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_pd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: handshakes sampled at negedge complete on the following posedge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (int'(fifo_used) > max_used) max_used = int'(fifo_used);
      if (prev_stall) begin
        check("stall_pvld", {513'd0, out_pvld}, 1);
        check("stall_pd", out_pd, prev_pd);
      end
      if (in_pvld && in_prdy) sb.push_back(in_pd);
      if (out_pvld && out_prdy) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got %0h expected none", out_pd);
        end else begin
          check("sb_data", out_pd, sb.pop_front());
        end
        pop_cnt++;
        last_pop_cyc = cyc;
      end
      prev_stall = out_pvld && !out_prdy;
      prev_pd    = out_pd;
    end
  end

  task automatic push_n(input int n, input int base, input int budget, input bit rnd, output int sent);
    int k;
    sent = 0;
    k = 0;
    while (sent < n && k < budget) begin
      in_pvld = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rnd) out_prdy = 1'($urandom_range(0, 1));
      in_pd = WIDTH'(base + sent);
      @(negedge clk);
      if (in_pvld && in_prdy) sent++;
      @(posedge clk);
      #1;
      k++;
    end
    in_pvld = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    check("drain_left", WIDTH'(sb.size()), 0);
  endtask

  // Push one word into an empty FIFO and check the cycle-exact re/ore/pvld sequence.
  task automatic single_push(input logic [WIDTH-1:0] v);
    in_pvld = 1'b1;
    in_pd   = v;
    out_prdy = 1'b1;
    @(negedge clk);
    check("lat_in_prdy", {513'd0, in_prdy}, 1);
    check("lat_re_t0", {513'd0, ram_re}, 0);
    @(posedge clk);
    #1 in_pvld = 1'b0;
    @(negedge clk);
    check("lat_re_t1", {513'd0, ram_re}, 1);
    check("lat_used_t1", WIDTH'(fifo_used), 1);
    @(negedge clk);
    check("lat_ore_t2", {513'd0, ram_ore}, 1);
    check("lat_pvld_t2", {513'd0, out_pvld}, 0);
    @(negedge clk);
    check("lat_pvld_t3", {513'd0, out_pvld}, 1);
    check("lat_pd_t3", out_pd, v);
    check("lat_used_t3", WIDTH'(fifo_used), 0);
    @(negedge clk);
    check("lat_pvld_t4", {513'd0, out_pvld}, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, mark, start_cyc;
    rst = 1'b1;
    in_pvld = 1'b0;
    in_pd = '0;
    out_prdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pvld", {513'd0, out_pvld}, 0);
    check("rst_in_prdy", {513'd0, in_prdy}, 0);
    check("rst_used", WIDTH'(fifo_used), 0);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    single_push(WIDTH'(32'hA5));

    // Fill with output stalled: 61 in RAM plus one in the output register.
    out_prdy = 1'b0;
    push_n(71, 0, 80, 1'b0, sent);
    check("fill_accepted", WIDTH'(sent), 62);
    @(negedge clk);
    check("full_in_prdy", {513'd0, in_prdy}, 0);
    check("full_used", WIDTH'(fifo_used), 61);
    check("full_pvld", {513'd0, out_pvld}, 1);
    check("full_pd", out_pd, 0);
    @(posedge clk);
    #1 out_prdy = 1'b1;
    @(negedge clk);
    check("drain_ore", {513'd0, ram_ore}, 1);
    check("drain_in_prdy_t0", {513'd0, in_prdy}, 0);
    @(negedge clk);
    check("drain_in_prdy_t1", {513'd0, in_prdy}, 1);
    wait_drain(200);
    check("drain_used", WIDTH'(fifo_used), 0);

    // Streaming: 200 items, wraps pointers three times, no bubbles after the fill.
    mark = pop_cnt;
    start_cyc = cyc;
    push_n(200, 1000, 400, 1'b0, sent);
    wait_drain(50);
    check("stream_sent", WIDTH'(sent), 200);
    check("stream_pops", WIDTH'(pop_cnt - mark), 200);
    check("stream_span", WIDTH'(last_pop_cyc - start_cyc), 202);

    // Random handshakes on both sides.
    push_n(5000, 5000, 40000, 1'b1, sent);
    out_prdy = 1'b1;
    wait_drain(200);
    check("rand_sent", WIDTH'(sent), 5000);
    check("max_used_le_61", WIDTH'(max_used > 61), 0);

    // Reset with live s1/s2 and 20 buffered entries.
    out_prdy = 1'b0;
    push_n(20, 'h300, 40, 1'b0, sent);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_pvld", {513'd0, out_pvld}, 0);
    check("arst_used", WIDTH'(fifo_used), 0);
    check("arst_re", {513'd0, ram_re}, 0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    single_push(WIDTH'(1));
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_empty", WIDTH'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end
endmodule
